// File: rtl/dot_product_pkg.sv
// Shared types and elaboration helpers for the row-by-vector MAC engine.
package dot_product_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Smallest accumulator that cannot overflow over a full row of products.
  function automatic int min_acc_w(input int pix_w, input int wgt_w,
                                   input int lanes, input int vec_len);
    return pix_w + wgt_w + 1 + $clog2(lanes * vec_len);
  endfunction

endpackage

// File: rtl/dot_product_engine_flex_counter.sv
// Up-counter with synchronous clear that wraps to zero after rollover_val.
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag
);

  localparam logic [NUM_CNT_BITS-1:0] ONE = {{(NUM_CNT_BITS-1){1'b0}}, 1'b1};

  logic [NUM_CNT_BITS-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_enable) begin
      count_d = (count_q == rollover_val) ? '0 : count_q + ONE;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count_out     = count_q;
  assign rollover_flag = (count_q == rollover_val);

endmodule

// File: rtl/dot_product_engine.sv
// Streams one weight row against the pixel vector from SRAM, LANES MACs per word,
// and emits a saturated or wrapped signed result per row (optionally all rows).
module dot_product_engine
  import dot_product_pkg::*;
#(
  parameter int LANES    = 2,
  parameter int PIX_W    = 8,
  parameter int WGT_W    = 16,
  parameter int VEC_LEN  = 392,
  parameter int NUM_ROWS = 10,
  parameter int MEM_LAT  = 1,
  parameter int ACC_W    = 36,
  parameter int OUT_W    = 16,
  parameter int PIX_BASE = 0,
  parameter int WGT_BASE = 0,
  parameter int PIX_AW   = 10,
  parameter int WGT_AW   = 12
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic                          start,
  input  logic                          all_rows,
  input  logic [$clog2(NUM_ROWS)-1:0]   row_select,
  input  logic                          sat_mode,
  input  logic [LANES*PIX_W-1:0]        pixel_value,
  input  logic [LANES*WGT_W-1:0]        weight_value,
  output logic                          rd_en,
  output logic [PIX_AW-1:0]             pixel_address,
  output logic [WGT_AW-1:0]             weight_address,
  output logic                          busy,
  output logic                          result_valid,
  output logic [OUT_W-1:0]              result,
  output logic [$clog2(NUM_ROWS)-1:0]   result_row,
  output logic                          overflow,
  output logic                          done
);

  localparam int ROW_W  = $clog2(NUM_ROWS);
  localparam int CNT_W  = $clog2(VEC_LEN + 1);
  localparam int PROD_W = PIX_W + WGT_W + 1;
  localparam int DRN_W  = $clog2(MEM_LAT + 1);
  localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OUT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  if (ACC_W < min_acc_w(PIX_W, WGT_W, LANES, VEC_LEN)) begin : g_acc_w_check
    $error("dot_product_engine: ACC_W too small for LANES*VEC_LEN products");
  end

  // Returns {overflow, result} for a finished row sum.
  function automatic logic [OUT_W:0] fmt_result(input logic signed [ACC_W-1:0] a,
                                                input logic sat);
    logic ovf;
    logic [OUT_W-1:0] res;
    ovf = (a > OUT_MAX) || (a < OUT_MIN);
    res = a[OUT_W-1:0];
    if (sat && ovf) res = a[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    return {ovf, res};
  endfunction

  state_e                    state_d, state_q;
  logic [ROW_W-1:0]          row_d, row_q;
  logic                      all_rows_d, all_rows_q;
  logic                      sat_d, sat_q;
  logic                      refill_d, refill_q;
  logic [DRN_W-1:0]          drain_d, drain_q;
  logic [MEM_LAT-1:0]        vld_sr_d, vld_sr_q;
  logic                      vld_p1_q;
  logic signed [ACC_W-1:0]   acc_d, acc_q;
  logic signed [ACC_W-1:0]   lane_sum;
  logic signed [PROD_W-1:0]  prod_p1_d [LANES];
  logic signed [PROD_W-1:0]  prod_p1_q [LANES];
  logic [OUT_W-1:0]          result_d, result_q;
  logic [ROW_W-1:0]          result_row_d, result_row_q;
  logic                      overflow_d, overflow_q;
  logic                      result_valid_d, result_valid_q;
  logic                      done_d, done_q;
  logic                      issuing, enter_issue, cnt_last, more_rows;
  logic [CNT_W-1:0]          cnt;

  // A row continued from DONE spends its first ISSUE cycle refilling before issuing.
  assign issuing     = (state_q == ISSUE) && !refill_q;
  assign enter_issue = (state_d == ISSUE) && (state_q != ISSUE);
  assign more_rows   = all_rows_q && (row_q != ROW_W'(NUM_ROWS - 1));

  flex_counter #(.NUM_CNT_BITS(CNT_W)) u_index_cnt (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (enter_issue),
    .count_enable  (issuing),
    .rollover_val  (CNT_W'(VEC_LEN - 1)),
    .count_out     (cnt),
    .rollover_flag (cnt_last)
  );

  always_comb begin
    state_d        = state_q;
    row_d          = row_q;
    all_rows_d     = all_rows_q;
    sat_d          = sat_q;
    refill_d       = 1'b0;
    drain_d        = drain_q;
    result_d       = result_q;
    result_row_d   = result_row_q;
    overflow_d     = overflow_q;
    result_valid_d = 1'b0;
    done_d         = 1'b0;
    unique case (state_q)
      IDLE: if (start) begin
        state_d    = ISSUE;
        all_rows_d = all_rows;
        sat_d      = sat_mode;
        row_d      = all_rows ? '0 : row_select;
      end
      ISSUE: if (issuing && cnt_last) begin
        state_d = DRAIN;
        drain_d = '0;
      end
      DRAIN: if (drain_q == DRN_W'(MEM_LAT)) begin
        state_d                  = DONE;
        {overflow_d, result_d}   = fmt_result(acc_d, sat_q);
        result_row_d             = row_q;
        result_valid_d           = 1'b1;
        done_d                   = !more_rows;
      end else begin
        drain_d = drain_q + DRN_W'(1);
      end
      DONE: if (more_rows) begin
        state_d  = ISSUE;
        row_d    = row_q + ROW_W'(1);
        refill_d = 1'b1;
      end else begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pixel_address  = PIX_AW'(PIX_BASE);
    weight_address = WGT_AW'(WGT_BASE);
    if (issuing) begin
      pixel_address  = PIX_AW'(PIX_BASE + int'(cnt));
      weight_address = WGT_AW'(WGT_BASE + int'(row_q) * VEC_LEN + int'(cnt));
    end
  end

  assign vld_sr_d = (vld_sr_q << 1) | MEM_LAT'(issuing);

  // Stage 1: per-lane zero-extended pixel times signed weight
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      prod_p1_d[l] = PROD_W'($signed({1'b0, pixel_value[l*PIX_W +: PIX_W]}))
                   * PROD_W'($signed(weight_value[l*WGT_W +: WGT_W]));
    end
  end

  always_ff @(posedge clk) begin
    prod_p1_q <= prod_p1_d;
  end

  // Stage 2: lane sum folded into the row accumulator
  always_comb begin
    lane_sum = '0;
    for (int l = 0; l < LANES; l++) lane_sum = lane_sum + ACC_W'(prod_p1_q[l]);
    acc_d = acc_q;
    if (enter_issue)   acc_d = '0;
    else if (vld_p1_q) acc_d = acc_q + lane_sum;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q        <= IDLE;
      row_q          <= '0;
      all_rows_q     <= 1'b0;
      sat_q          <= 1'b0;
      refill_q       <= 1'b0;
      drain_q        <= '0;
      vld_sr_q       <= '0;
      vld_p1_q       <= 1'b0;
      acc_q          <= '0;
      result_q       <= '0;
      result_row_q   <= '0;
      overflow_q     <= 1'b0;
      result_valid_q <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      row_q          <= row_d;
      all_rows_q     <= all_rows_d;
      sat_q          <= sat_d;
      refill_q       <= refill_d;
      drain_q        <= drain_d;
      vld_sr_q       <= vld_sr_d;
      vld_p1_q       <= vld_sr_q[MEM_LAT-1];
      acc_q          <= acc_d;
      result_q       <= result_d;
      result_row_q   <= result_row_d;
      overflow_q     <= overflow_d;
      result_valid_q <= result_valid_d;
      done_q         <= done_d;
    end
  end

  assign rd_en        = issuing;
  assign busy         = (state_q != IDLE);
  assign result       = result_q;
  assign result_row   = result_row_q;
  assign overflow     = overflow_q;
  assign result_valid = result_valid_q;
  assign done         = done_q;

endmodule

// File: tb/tb_dot_product_engine.sv
// Directed bench: default-config engine (MEM_LAT=1) plus an all-rows engine with MEM_LAT=2.
module tb_dot_product_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        n_rst, start1, start2, all_rows, sat_mode;
  logic [3:0]  row_select;

  logic [15:0] pix1, pix2, pix2_s1;
  logic [31:0] wgt1, wgt2, wgt2_s1;
  logic        rd_en1, busy1, rv1, ovf1, done1;
  logic        rd_en2, busy2, rv2, ovf2, done2;
  logic [9:0]  paddr1, paddr2;
  logic [11:0] waddr1, waddr2;
  logic [15:0] res1, res2;
  logic [3:0]  rrow1, rrow2;

  logic [15:0] pix_mem [0:1023];
  logic [31:0] wgt_mem [0:4095];

  int n_cmp = 0;
  int n_bad = 0;

  dot_product_engine u_dut1 (
    .clk(clk), .n_rst(n_rst), .start(start1), .all_rows(all_rows),
    .row_select(row_select), .sat_mode(sat_mode),
    .pixel_value(pix1), .weight_value(wgt1),
    .rd_en(rd_en1), .pixel_address(paddr1), .weight_address(waddr1),
    .busy(busy1), .result_valid(rv1), .result(res1), .result_row(rrow1),
    .overflow(ovf1), .done(done1)
  );

  dot_product_engine #(.MEM_LAT(2)) u_dut2 (
    .clk(clk), .n_rst(n_rst), .start(start2), .all_rows(all_rows),
    .row_select(row_select), .sat_mode(sat_mode),
    .pixel_value(pix2), .weight_value(wgt2),
    .rd_en(rd_en2), .pixel_address(paddr2), .weight_address(waddr2),
    .busy(busy2), .result_valid(rv2), .result(res2), .result_row(rrow2),
    .overflow(ovf2), .done(done2)
  );

  always @(posedge clk) begin
    pix1    <= pix_mem[paddr1];
    wgt1    <= wgt_mem[waddr1];
    pix2_s1 <= pix_mem[paddr2];
    wgt2_s1 <= wgt_mem[waddr2];
    pix2    <= pix2_s1;
    wgt2    <= wgt2_s1;
  end

  task automatic fill(input logic [7:0] p, input logic [15:0] w, input bit per_row);
    logic [15:0] wr;
    for (int a = 0; a < 1024; a++) pix_mem[a] = {p, p};
    for (int a = 0; a < 4096; a++) begin
      wr = per_row ? 16'(a / 392 + 1) : w;
      wgt_mem[a] = {wr, wr};
    end
  endtask

  // Starts a single-row run on dut1, scrambles config right after, returns at the result cycle.
  task automatic run_single(input logic [3:0] row, input logic sat, output int lat);
    @(posedge clk); #1;
    start1 = 1'b1; row_select = row; sat_mode = sat; all_rows = 1'b0;
    @(posedge clk); #1;
    start1 = 1'b0; sat_mode = ~sat; row_select = row + 4'd1; all_rows = 1'b1;
    lat = -1;
    for (int n = 1; n < 600; n++) begin
      @(negedge clk);
      if (rv1) begin lat = n; break; end
    end
  endtask

  task automatic test_reset;
    n_rst = 1'b0; start1 = 1'b0; start2 = 1'b0;
    all_rows = 1'b0; sat_mode = 1'b0; row_select = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({rd_en1, paddr1, waddr1, busy1, rv1, res1, rrow1, ovf1, done1} !== '0) begin
      n_bad++; $display("FAIL reset_dut1: got %h want 0",
        {rd_en1, paddr1, waddr1, busy1, rv1, res1, rrow1, ovf1, done1});
    end
    n_cmp++;
    if ({rd_en2, paddr2, waddr2, busy2, rv2, res2, rrow2, ovf2, done2} !== '0) begin
      n_bad++; $display("FAIL reset_dut2: got %h want 0",
        {rd_en2, paddr2, waddr2, busy2, rv2, res2, rrow2, ovf2, done2});
    end
    @(negedge clk); n_rst = 1'b1;
  endtask

  task automatic test_basic;
    int lat;
    fill(8'h01, 16'h0001, 1'b0);
    run_single(4'd0, 1'b0, lat);
    n_cmp++; if (lat !== 395) begin n_bad++; $display("FAIL basic_latency: got %0d want 395", lat); end
    n_cmp++; if (res1 !== 16'h0310) begin n_bad++; $display("FAIL basic_result: got %h want 0310", res1); end
    n_cmp++; if (ovf1 !== 1'b0) begin n_bad++; $display("FAIL basic_overflow: got %b want 0", ovf1); end
    n_cmp++; if (done1 !== 1'b1) begin n_bad++; $display("FAIL basic_done: got %b want 1", done1); end
    n_cmp++; if (rrow1 !== 4'd0) begin n_bad++; $display("FAIL basic_row: got %0d want 0", rrow1); end
    @(negedge clk);
    n_cmp++; if (rv1 !== 1'b0 || done1 !== 1'b0) begin
      n_bad++; $display("FAIL basic_pulse_width: got rv=%b done=%b want 0/0", rv1, done1); end
    n_cmp++; if (res1 !== 16'h0310 || busy1 !== 1'b0) begin
      n_bad++; $display("FAIL basic_hold_idle: got res=%h busy=%b want 0310/0", res1, busy1); end
  endtask

  task automatic test_sat_wrap;
    int lat;
    fill(8'hFF, 16'h7FFF, 1'b0);
    run_single(4'd0, 1'b1, lat);
    n_cmp++; if (res1 !== 16'h7FFF) begin n_bad++; $display("FAIL sat_result: got %h want 7fff", res1); end
    n_cmp++; if (ovf1 !== 1'b1) begin n_bad++; $display("FAIL sat_overflow: got %b want 1", ovf1); end
    run_single(4'd0, 1'b0, lat);
    n_cmp++; if (lat !== 395) begin n_bad++; $display("FAIL restart_latency: got %0d want 395", lat); end
    n_cmp++; if (res1 !== 16'hF310) begin n_bad++; $display("FAIL wrap_result: got %h want f310", res1); end
    n_cmp++; if (ovf1 !== 1'b1) begin n_bad++; $display("FAIL wrap_overflow: got %b want 1", ovf1); end
  endtask

  task automatic test_negative;
    int lat;
    fill(8'h02, 16'hFFFF, 1'b0);
    run_single(4'd0, 1'b1, lat);
    n_cmp++; if (res1 !== 16'hF9E0) begin n_bad++; $display("FAIL neg_result: got %h want f9e0", res1); end
    n_cmp++; if (ovf1 !== 1'b0) begin n_bad++; $display("FAIL neg_overflow: got %b want 0", ovf1); end
  endtask

  task automatic test_row_addr;
    int cnt, idle_bad;
    logic [11:0] fw, lw;
    logic [9:0]  fp, lp;
    bit seen;
    fill(8'h01, 16'h0001, 1'b0);
    cnt = 0; idle_bad = 0; seen = 1'b0; fw = '0; lw = '0; fp = '0; lp = '0;
    @(posedge clk); #1;
    start1 = 1'b1; row_select = 4'd3; all_rows = 1'b0; sat_mode = 1'b0;
    @(posedge clk); #1;
    start1 = 1'b0; row_select = 4'd7;
    for (int n = 1; n < 600; n++) begin
      @(negedge clk);
      if (rd_en1) begin
        if (!seen) begin fw = waddr1; fp = paddr1; seen = 1'b1; end
        lw = waddr1; lp = paddr1; cnt++;
      end else if (paddr1 !== 10'd0 || waddr1 !== 12'd0) begin
        idle_bad++;
      end
      if (rv1) break;
    end
    n_cmp++; if (cnt !== 392) begin n_bad++; $display("FAIL row_rd_en_count: got %0d want 392", cnt); end
    n_cmp++; if (fw !== 12'h498) begin n_bad++; $display("FAIL row_first_waddr: got %h want 498", fw); end
    n_cmp++; if (lw !== 12'h61F) begin n_bad++; $display("FAIL row_last_waddr: got %h want 61f", lw); end
    n_cmp++; if (fp !== 10'h000 || lp !== 10'h187) begin
      n_bad++; $display("FAIL row_paddr_range: got %h..%h want 000..187", fp, lp); end
    n_cmp++; if (idle_bad !== 0) begin n_bad++; $display("FAIL row_idle_addr: got %0d off-base cycles want 0", idle_bad); end
    n_cmp++; if (rrow1 !== 4'd3 || res1 !== 16'h0310) begin
      n_bad++; $display("FAIL row_result: got row=%0d res=%h want 3/0310", rrow1, res1); end
  endtask

  task automatic test_all_rows;
    int pulses, last_n, extra, orphan_done;
    fill(8'h01, 16'h0000, 1'b1);
    pulses = 0; last_n = 0; extra = 0; orphan_done = 0;
    @(posedge clk); #1;
    start2 = 1'b1; all_rows = 1'b1; row_select = 4'd6; sat_mode = 1'b0;
    @(posedge clk); #1;
    start2 = 1'b0; all_rows = 1'b0;
    for (int n = 1; n < 4500 && pulses < 10; n++) begin
      @(negedge clk);
      if (start2) start2 = 1'b0;
      if (done2 && !rv2) orphan_done++;
      if (rv2) begin
        n_cmp++;
        if (n - last_n !== (pulses == 0 ? 396 : 397)) begin
          n_bad++; $display("FAIL all_rows_spacing: row %0d got %0d want %0d",
            pulses, n - last_n, (pulses == 0 ? 396 : 397));
        end
        n_cmp++;
        if (rrow2 !== 4'(pulses) || res2 !== 16'(784 * (pulses + 1))) begin
          n_bad++; $display("FAIL all_rows_value: got row=%0d res=%0d want %0d/%0d",
            rrow2, res2, pulses, 784 * (pulses + 1));
        end
        n_cmp++;
        if (done2 !== (pulses == 9)) begin
          n_bad++; $display("FAIL all_rows_done: row %0d got %b want %b", pulses, done2, pulses == 9);
        end
        last_n = n; pulses++;
        if (pulses == 3) begin row_select = 4'd5; start2 = 1'b1; end
      end
    end
    n_cmp++; if (pulses !== 10) begin n_bad++; $display("FAIL all_rows_count: got %0d want 10", pulses); end
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      if (rv2 || done2) extra++;
    end
    n_cmp++; if (extra !== 0 || busy2 !== 1'b0) begin
      n_bad++; $display("FAIL all_rows_quiet: got extra=%0d busy=%b want 0/0", extra, busy2); end
    n_cmp++; if (orphan_done !== 0) begin n_bad++; $display("FAIL all_rows_orphan_done: got %0d want 0", orphan_done); end
  endtask

  task automatic test_reset_mid;
    int lat;
    bit hit;
    fill(8'h01, 16'h0001, 1'b0);
    hit = 1'b0;
    @(posedge clk); #1;
    start1 = 1'b1; row_select = 4'd2; all_rows = 1'b0; sat_mode = 1'b0;
    @(posedge clk); #1;
    start1 = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (rd_en1 && paddr1 == 10'd100) begin hit = 1'b1; break; end
    end
    n_cmp++; if (!hit) begin n_bad++; $display("FAIL mid_reset_reach: got no index 100 want index 100"); end
    n_rst = 1'b0;
    #1;
    n_cmp++;
    if ({rd_en1, paddr1, waddr1, busy1, rv1, res1, rrow1, ovf1, done1} !== '0) begin
      n_bad++; $display("FAIL mid_reset_outputs: got %h want 0",
        {rd_en1, paddr1, waddr1, busy1, rv1, res1, rrow1, ovf1, done1});
    end
    @(negedge clk); n_rst = 1'b1;
    run_single(4'd1, 1'b0, lat);
    n_cmp++; if (lat !== 395) begin n_bad++; $display("FAIL post_reset_latency: got %0d want 395", lat); end
    n_cmp++; if (res1 !== 16'h0310 || ovf1 !== 1'b0 || rrow1 !== 4'd1) begin
      n_bad++; $display("FAIL post_reset_result: got res=%h ovf=%b row=%0d want 0310/0/1", res1, ovf1, rrow1); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_sat_wrap;
    test_negative;
    test_row_addr;
    test_all_rows;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
